// File: rtl/fp_wb_arbiter.sv
// -----------------------------------------------------------------------------
// fp_wb_arbiter
//
// Purpose:
//   Writeback arbiter for the floating-point register file. Tracks which FP
//   registers have an in-flight write (pending mask), stalls issue on a WAW
//   hazard, and merges three producer streams (FP load, FP add/mul,
//   FP div/sqrt) into one registered writeback port using round-robin
//   arbitration.
//
// Ports:
//   clk, rst_n              clock / asynchronous active-low reset
//   iss_valid, iss_rdf      issuing FP instruction and its destination
//   iss_stall               issue blocked: destination already pending
//   srcK_valid/ready        per-source handshake (K = 0 load, 1 add/mul,
//   srcK_rdf/data             2 div/sqrt); ready is the combinational grant
//   wb_we/wb_addrf/wb_dataf registered write port to the FP register file
//   rs1f/rs2f               hazard-query addresses
//   rs1f_busy/rs2f_busy     queried register still has a pending write
//   err_unexp               sticky: a write arrived for a non-pending register
// -----------------------------------------------------------------------------
module fp_wb_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  // issue side
  input  logic              iss_valid,
  input  logic [ADDR_W-1:0] iss_rdf,
  output logic              iss_stall,
  // source 0: FP load
  input  logic              src0_valid,
  output logic              src0_ready,
  input  logic [ADDR_W-1:0] src0_rdf,
  input  logic [DATA_W-1:0] src0_data,
  // source 1: FP add/mul
  input  logic              src1_valid,
  output logic              src1_ready,
  input  logic [ADDR_W-1:0] src1_rdf,
  input  logic [DATA_W-1:0] src1_data,
  // source 2: FP div/sqrt
  input  logic              src2_valid,
  output logic              src2_ready,
  input  logic [ADDR_W-1:0] src2_rdf,
  input  logic [DATA_W-1:0] src2_data,
  // register file write port
  output logic              wb_we,
  output logic [ADDR_W-1:0] wb_addrf,
  output logic [DATA_W-1:0] wb_dataf,
  // hazard queries
  input  logic [ADDR_W-1:0] rs1f,
  input  logic [ADDR_W-1:0] rs2f,
  output logic              rs1f_busy,
  output logic              rs2f_busy,
  // status
  output logic              err_unexp
);

  localparam int NREG = 1 << ADDR_W;

  logic [NREG-1:0]   pending_q, pending_d;
  logic [NREG-1:0]   set_mask, clr_mask;
  logic [1:0]        rr_ptr_q, rr_ptr_d;
  logic              wb_we_q, wb_we_d;
  logic [ADDR_W-1:0] wb_addrf_q, wb_addrf_d;
  logic [DATA_W-1:0] wb_dataf_q, wb_dataf_d;
  logic              err_q, err_d;

  logic              set_en;
  logic              any_valid;
  logic              xfer;
  logic [1:0]        grant_idx;
  logic [ADDR_W-1:0] xfer_rdf;
  logic [DATA_W-1:0] xfer_data;
  logic              xfer_unexp;

  // ---------------------------------------------------------------------------
  // Hazard tracking
  // ---------------------------------------------------------------------------
  assign iss_stall = iss_valid && pending_q[iss_rdf];
  assign set_en    = iss_valid && !iss_stall;
  assign rs1f_busy = pending_q[rs1f];
  assign rs2f_busy = pending_q[rs2f];

  // Clear lands on the edge the register file commits the write; a
  // simultaneous set for the same register takes precedence.
  always_comb begin
    set_mask  = '0;
    clr_mask  = '0;
    if (set_en)  set_mask[iss_rdf]    = 1'b1;
    if (wb_we_q) clr_mask[wb_addrf_q] = 1'b1;
    pending_d = (pending_q & ~clr_mask) | set_mask;
  end

  // ---------------------------------------------------------------------------
  // Round-robin arbitration: search starts at rr_ptr_q and wraps 2 -> 0.
  // ---------------------------------------------------------------------------
  always_comb begin
    grant_idx = 2'd0;
    case (rr_ptr_q)
      2'd1:    grant_idx = src1_valid ? 2'd1 : (src2_valid ? 2'd2 : 2'd0);
      2'd2:    grant_idx = src2_valid ? 2'd2 : (src0_valid ? 2'd0 : 2'd1);
      default: grant_idx = src0_valid ? 2'd0 : (src1_valid ? 2'd1 : 2'd2);
    endcase
  end

  assign any_valid = src0_valid || src1_valid || src2_valid;
  // Reset is asynchronous, so grants are masked directly by rst_n to keep
  // every ready low for the whole time reset is held.
  assign xfer = any_valid && rst_n;

  assign src0_ready = xfer && (grant_idx == 2'd0);
  assign src1_ready = xfer && (grant_idx == 2'd1);
  assign src2_ready = xfer && (grant_idx == 2'd2);

  always_comb begin
    xfer_rdf  = src0_rdf;
    xfer_data = src0_data;
    case (grant_idx)
      2'd1: begin
        xfer_rdf  = src1_rdf;
        xfer_data = src1_data;
      end
      2'd2: begin
        xfer_rdf  = src2_rdf;
        xfer_data = src2_data;
      end
      default: begin
        xfer_rdf  = src0_rdf;
        xfer_data = src0_data;
      end
    endcase
  end

  // A write for a register that is neither pending nor being claimed by the
  // instruction issuing on this very edge has no owner.
  assign xfer_unexp = xfer && !pending_q[xfer_rdf] &&
                      !(set_en && (iss_rdf == xfer_rdf));

  always_comb begin
    rr_ptr_d   = rr_ptr_q;
    wb_we_d    = xfer;
    wb_addrf_d = wb_addrf_q;
    wb_dataf_d = wb_dataf_q;
    err_d      = err_q || xfer_unexp;
    if (xfer) begin
      rr_ptr_d   = (grant_idx == 2'd2) ? 2'd0 : grant_idx + 2'd1;
      wb_addrf_d = xfer_rdf;
      wb_dataf_d = xfer_data;
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q  <= '0;
      rr_ptr_q   <= 2'd0;
      wb_we_q    <= 1'b0;
      wb_addrf_q <= '0;
      wb_dataf_q <= '0;
      err_q      <= 1'b0;
    end else begin
      pending_q  <= pending_d;
      rr_ptr_q   <= rr_ptr_d;
      wb_we_q    <= wb_we_d;
      wb_addrf_q <= wb_addrf_d;
      wb_dataf_q <= wb_dataf_d;
      err_q      <= err_d;
    end
  end

  assign wb_we     = wb_we_q;
  assign wb_addrf  = wb_addrf_q;
  assign wb_dataf  = wb_dataf_q;
  assign err_unexp = err_q;

endmodule

// File: tb/tb_fp_wb_arbiter.sv
// -----------------------------------------------------------------------------
// tb_fp_wb_arbiter
//
// Directed bench for fp_wb_arbiter. Each table row is one clock cycle: inputs
// are driven on the falling edge and all outputs are compared 1 ns later,
// so registered outputs show the result of the previous rising edge.
// Hand-written sequences cover reset behaviour.
// -----------------------------------------------------------------------------
module tb_fp_wb_arbiter;

  logic        clk;
  logic        rst_n;
  logic        iss_valid;
  logic [4:0]  iss_rdf;
  logic        iss_stall;
  logic        src0_valid, src1_valid, src2_valid;
  logic        src0_ready, src1_ready, src2_ready;
  logic [4:0]  src0_rdf, src1_rdf, src2_rdf;
  logic [31:0] src0_data, src1_data, src2_data;
  logic        wb_we;
  logic [4:0]  wb_addrf;
  logic [31:0] wb_dataf;
  logic [4:0]  rs1f, rs2f;
  logic        rs1f_busy, rs2f_busy;
  logic        err_unexp;

  int checks = 0;
  int errors = 0;

  fp_wb_arbiter #(.DATA_W(32), .ADDR_W(5)) dut (
    .clk(clk), .rst_n(rst_n),
    .iss_valid(iss_valid), .iss_rdf(iss_rdf), .iss_stall(iss_stall),
    .src0_valid(src0_valid), .src0_ready(src0_ready), .src0_rdf(src0_rdf), .src0_data(src0_data),
    .src1_valid(src1_valid), .src1_ready(src1_ready), .src1_rdf(src1_rdf), .src1_data(src1_data),
    .src2_valid(src2_valid), .src2_ready(src2_ready), .src2_rdf(src2_rdf), .src2_data(src2_data),
    .wb_we(wb_we), .wb_addrf(wb_addrf), .wb_dataf(wb_dataf),
    .rs1f(rs1f), .rs2f(rs2f), .rs1f_busy(rs1f_busy), .rs2f_busy(rs2f_busy),
    .err_unexp(err_unexp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        iss_v;
    logic [4:0]  iss_rdf;
    logic [2:0]  v;      // {src2, src1, src0}
    logic [4:0]  rdf0, rdf1, rdf2;
    logic [31:0] d0, d1, d2;
    logic [4:0]  rs1, rs2;
    logic        e_stall;
    logic [2:0]  e_rdy;  // {src2, src1, src0}
    logic        e_we;
    logic [4:0]  e_addr;
    logic [31:0] e_data;
    logic        e_b1, e_b2, e_err;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(
    input logic iss_v, input logic [4:0] iss_r, input logic [2:0] v,
    input logic [4:0] r0, input logic [4:0] r1, input logic [4:0] r2,
    input logic [31:0] d0, input logic [31:0] d1, input logic [31:0] d2,
    input logic [4:0] q1, input logic [4:0] q2,
    input logic e_stall, input logic [2:0] e_rdy, input logic e_we,
    input logic [4:0] e_addr, input logic [31:0] e_data,
    input logic e_b1, input logic e_b2, input logic e_err);
    vec_t t;
    t = '{iss_v, iss_r, v, r0, r1, r2, d0, d1, d2, q1, q2,
          e_stall, e_rdy, e_we, e_addr, e_data, e_b1, e_b2, e_err};
    return t;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic drive(input vec_t t);
    iss_valid  = t.iss_v;
    iss_rdf    = t.iss_rdf;
    src0_valid = t.v[0];
    src1_valid = t.v[1];
    src2_valid = t.v[2];
    src0_rdf   = t.rdf0;
    src1_rdf   = t.rdf1;
    src2_rdf   = t.rdf2;
    src0_data  = t.d0;
    src1_data  = t.d1;
    src2_data  = t.d2;
    rs1f       = t.rs1;
    rs2f       = t.rs2;
  endtask

  function automatic logic [2:0] rdy();
    return {src2_ready, src1_ready, src0_ready};
  endfunction

  initial begin
    vec_t idle;
    idle = mk(0,0,3'b000, 0,0,0, 0,0,0, 0,0, 0,3'b000,0,0,0,0,0,0);

    // iss  rd  v       rdf0 1  2  d0           d1           d2           rs1 rs2 | stall rdy    we addr data         b1 b2 err
    vecs.push_back(mk(1,3,3'b000, 0,0,0, 0,0,0,                                        3,0, 0,3'b000,0,0,32'h0,         0,0,0)); // A issue f3
    vecs.push_back(mk(0,0,3'b010, 0,3,0, 0,32'h3F800000,0,                             3,0, 0,3'b010,0,0,32'h0,         1,0,0)); // B src1 -> f3
    vecs.push_back(mk(0,0,3'b000, 0,0,0, 0,0,0,                                        3,0, 0,3'b000,1,3,32'h3F800000,  1,0,0)); // C wb f3
    vecs.push_back(mk(0,0,3'b000, 0,0,0, 0,0,0,                                        3,0, 0,3'b000,0,3,32'h3F800000,  0,0,0)); // D busy dropped
    vecs.push_back(mk(1,5,3'b000, 0,0,0, 0,0,0,                                        5,3, 0,3'b000,0,3,32'h3F800000,  0,0,0)); // E issue f5
    vecs.push_back(mk(1,5,3'b000, 0,0,0, 0,0,0,                                        5,3, 1,3'b000,0,3,32'h3F800000,  1,0,0)); // F WAW stall
    vecs.push_back(mk(1,5,3'b001, 5,0,0, 32'h40000000,0,0,                             5,3, 1,3'b001,0,3,32'h3F800000,  1,0,0)); // G src0 -> f5
    vecs.push_back(mk(1,5,3'b000, 0,0,0, 0,0,0,                                        5,3, 1,3'b000,1,5,32'h40000000,  1,0,0)); // H wb f5
    vecs.push_back(mk(1,5,3'b000, 0,0,0, 0,0,0,                                        5,3, 0,3'b000,0,5,32'h40000000,  0,0,0)); // I issue proceeds
    vecs.push_back(mk(1,4,3'b100, 0,0,4, 0,0,32'h11112222,                             4,5, 0,3'b100,0,5,32'h40000000,  0,1,0)); // J issue f4 + xfer f4
    vecs.push_back(mk(0,0,3'b000, 0,0,0, 0,0,0,                                        4,5, 0,3'b000,1,4,32'h11112222,  1,1,0)); // K f4 pending after edge
    vecs.push_back(mk(0,0,3'b000, 0,0,0, 0,0,0,                                        4,5, 0,3'b000,0,4,32'h11112222,  0,1,0)); // L
    vecs.push_back(mk(0,0,3'b100, 0,0,7, 0,0,32'hDEADBEEF,                             7,5, 0,3'b100,0,4,32'h11112222,  0,1,0)); // M unexpected f7
    vecs.push_back(mk(1,7,3'b000, 0,0,0, 0,0,0,                                        7,5, 0,3'b000,1,7,32'hDEADBEEF,  0,1,1)); // N set vs clear f7
    vecs.push_back(mk(1,7,3'b000, 0,0,0, 0,0,0,                                        7,5, 1,3'b000,0,7,32'hDEADBEEF,  1,1,1)); // O set won
    vecs.push_back(mk(0,0,3'b111, 5,7,1, 32'hA0,32'hA1,32'hA2,                         5,7, 0,3'b001,0,7,32'hDEADBEEF,  1,1,1)); // P all valid
    vecs.push_back(mk(0,0,3'b111, 5,7,1, 32'hA0,32'hA1,32'hA2,                         5,7, 0,3'b010,1,5,32'hA0,        1,1,1)); // Q
    vecs.push_back(mk(0,0,3'b111, 5,7,1, 32'hA0,32'hA1,32'hA2,                         5,7, 0,3'b100,1,7,32'hA1,        0,1,1)); // R
    vecs.push_back(mk(0,0,3'b111, 5,7,1, 32'hA0,32'hA1,32'hA2,                         5,7, 0,3'b001,1,1,32'hA2,        0,0,1)); // S
    vecs.push_back(mk(0,0,3'b000, 0,0,0, 0,0,0,                                        5,7, 0,3'b000,1,5,32'hA0,        0,0,1)); // T

    // ---------------- reset state ----------------
    rst_n = 1'b0;
    drive(idle);
    #2;
    iss_valid = 1'b1; iss_rdf = 5'd3;
    src0_valid = 1'b1; src1_valid = 1'b1; src2_valid = 1'b1;
    rs1f = 5'd3; rs2f = 5'd0;
    #1;
    chk("reset ready",    32'(rdy()), 32'h0);
    chk("reset wb_we",    32'(wb_we), 32'h0);
    chk("reset wb_addrf", 32'(wb_addrf), 32'h0);
    chk("reset wb_dataf", wb_dataf, 32'h0);
    chk("reset stall",    32'(iss_stall), 32'h0);
    chk("reset busy",     32'(rs1f_busy), 32'h0);
    chk("reset err",      32'(err_unexp), 32'h0);
    @(negedge clk);
    @(negedge clk);
    drive(idle);
    rst_n = 1'b1;
    #1;
    chk("post-reset wb_we", 32'(wb_we), 32'h0);
    $display("reset: ready=%b wb_we=%b err=%b", rdy(), wb_we, err_unexp);

    // ---------------- table ----------------
    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i]);
      #1;
      chk($sformatf("row%0d iss_stall", i), 32'(iss_stall), 32'(vecs[i].e_stall));
      chk($sformatf("row%0d ready", i),     32'(rdy()),     32'(vecs[i].e_rdy));
      chk($sformatf("row%0d wb_we", i),     32'(wb_we),     32'(vecs[i].e_we));
      chk($sformatf("row%0d wb_addrf", i),  32'(wb_addrf),  32'(vecs[i].e_addr));
      chk($sformatf("row%0d wb_dataf", i),  wb_dataf,       vecs[i].e_data);
      chk($sformatf("row%0d rs1f_busy", i), 32'(rs1f_busy), 32'(vecs[i].e_b1));
      chk($sformatf("row%0d rs2f_busy", i), 32'(rs2f_busy), 32'(vecs[i].e_b2));
      chk($sformatf("row%0d err_unexp", i), 32'(err_unexp), 32'(vecs[i].e_err));
      $display("row%0d: stall=%b ready=%b wb_we=%b addr=%0d data=%h busy=%b%b err=%b",
               i, iss_stall, rdy(), wb_we, wb_addrf, wb_dataf, rs1f_busy, rs2f_busy, err_unexp);
    end

    // ---------------- asynchronous reset mid-operation ----------------
    @(negedge clk);
    drive(idle);
    iss_valid = 1'b1; iss_rdf = 5'd1;
    @(negedge clk);
    iss_rdf = 5'd2;
    src0_valid = 1'b1; src0_rdf = 5'd1; src0_data = 32'hB0;
    src1_valid = 1'b1; src1_rdf = 5'd2; src1_data = 32'hB1;
    src2_valid = 1'b1; src2_rdf = 5'd9; src2_data = 32'hB2;
    #1;
    chk("pre-rst grant src1", 32'(rdy()), 32'b010);
    @(negedge clk);
    iss_valid = 1'b0;
    rs1f = 5'd1; rs2f = 5'd2;
    #1;
    chk("pre-rst busy f1", 32'(rs1f_busy), 32'h1);
    chk("pre-rst busy f2", 32'(rs2f_busy), 32'h1);
    chk("pre-rst wb_we",   32'(wb_we), 32'h1);
    chk("pre-rst err",     32'(err_unexp), 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async rst busy f1", 32'(rs1f_busy), 32'h0);
    chk("async rst busy f2", 32'(rs2f_busy), 32'h0);
    chk("async rst wb_we",   32'(wb_we), 32'h0);
    chk("async rst wb_addrf", 32'(wb_addrf), 32'h0);
    chk("async rst ready",   32'(rdy()), 32'h0);
    chk("async rst err",     32'(err_unexp), 32'h0);
    $display("async reset: busy=%b%b wb_we=%b ready=%b err=%b", rs1f_busy, rs2f_busy, wb_we, rdy(), err_unexp);
    @(negedge clk);
    #1;
    chk("held rst ready", 32'(rdy()), 32'h0);
    chk("held rst wb_we", 32'(wb_we), 32'h0);
    rst_n = 1'b1;
    #1;
    chk("restart grant src0", 32'(rdy()), 32'b001);
    @(negedge clk);
    #1;
    chk("restart wb_we",    32'(wb_we), 32'h1);
    chk("restart wb_addrf", 32'(wb_addrf), 32'd1);
    chk("restart wb_dataf", wb_dataf, 32'hB0);
    chk("restart grant src1", 32'(rdy()), 32'b010);
    @(negedge clk);
    #1;
    chk("rr wb_addrf", 32'(wb_addrf), 32'd2);
    chk("rr wb_dataf", wb_dataf, 32'hB1);
    chk("rr grant src2", 32'(rdy()), 32'b100);
    $display("restart: ready=%b wb_we=%b addr=%0d data=%h", rdy(), wb_we, wb_addrf, wb_dataf);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
